inst_encoder: RTL and testbench

Pipelined RV32I instruction encoder: accepts decoded fields (format, opcode, registers, funct3/funct7, 32-bit immediate) and packs them into a 32-bit instruction word, scattering immediate bits exactly inverse to the core's immediate decode. It sits between the UART/SPI program loader and instruction memory, so host-side field records become executable words. It also range-checks the immediate and keeps encode and error statistics.

---
 rtl/rv32_enc_pkg.sv | 43 ++++
 rtl/inst_pack.sv | 52 +++++
 rtl/inst_encoder.sv | 134 +++++++++++++
 tb/tb_inst_encoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// The format enum, NOP word, opcodes, the stage-1 record and a signed-range helper.
package rv32_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_REG    = 7'h33;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } rec_t;

  // True when imm is representable as a signed value of the given bit count.
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(imm) >>> (bits - 1);
    return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer: scatters immediate bits into the instruction word
// (inverse of the core's immediate decode) and flags out-of-range immediates or bad formats.
module inst_pack
  import rv32_enc_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o,
  output logic        err_o
);

  // Per-format packing; errored words are still packed from the truncated bits.
  always_comb begin
    inst_o = NOP;
    err_o  = 1'b0;
    case (fmt_e'(fmt_i))
      FMT_R: inst_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: begin
        inst_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        err_o  = !fits_signed(imm_i, 32'd12);
      end
      FMT_S: begin
        inst_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        err_o  = !fits_signed(imm_i, 32'd12);
      end
      FMT_B: begin
        inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                  imm_i[4:1], imm_i[11], opcode_i};
        err_o  = !fits_signed(imm_i, 32'd13) || imm_i[0];
      end
      FMT_U: begin
        inst_o = {imm_i[31:12], rd_i, opcode_i};
        err_o  = (imm_i[11:0] != 12'h000);
      end
      FMT_J: begin
        inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        err_o  = !fits_signed(imm_i, 32'd21) || imm_i[0];
      end
      default: begin
        inst_o = NOP;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage pipelined RV32I encoder with valid/ready handshakes and
// hand-off statistics (wrapping encode count, saturating error count).
module inst_encoder
  import rv32_enc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  input  logic        cnt_clr,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  logic        s1_valid_q, s1_valid_d;
  rec_t        s1_rec_q, s1_rec_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_err_q, out_err_d;
  logic [15:0] enc_q, enc_d;
  logic [15:0] err_q, err_d;

  logic        s1_ready_s, s2_ready_s, hs_s;
  logic [31:0] pack_inst_s;
  logic        pack_err_s;

  inst_pack u_pack (
    .fmt_i    (s1_rec_q.fmt),
    .opcode_i (s1_rec_q.opcode),
    .rd_i     (s1_rec_q.rd),
    .rs1_i    (s1_rec_q.rs1),
    .rs2_i    (s1_rec_q.rs2),
    .funct3_i (s1_rec_q.funct3),
    .funct7_i (s1_rec_q.funct7),
    .imm_i    (s1_rec_q.imm),
    .inst_o   (pack_inst_s),
    .err_o    (pack_err_s)
  );

  assign s2_ready_s = !out_valid_q || out_ready;
  assign s1_ready_s = !s1_valid_q || s2_ready_s;
  assign hs_s       = out_valid_q && out_ready;

  // Next-state for both pipeline stages and the statistics counters.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_rec_d    = s1_rec_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    enc_d       = enc_q;
    err_d       = err_q;

    if (s1_ready_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_rec_d = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                     rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};
      end else begin
        s1_rec_d = s1_rec_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_ready_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_inst_d = pack_inst_s;
        out_err_d  = pack_err_s;
      end else begin
        out_inst_d = out_inst_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end

    // Clear takes priority over a same-cycle hand-off.
    if (cnt_clr) begin
      enc_d = 16'h0000;
      err_d = 16'h0000;
    end else if (hs_s) begin
      enc_d = enc_q + 16'h0001;
      if (out_err_q && (err_q != 16'hFFFF)) begin
        err_d = err_q + 16'h0001;
      end else begin
        err_d = err_q;
      end
    end else begin
      enc_d = enc_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_rec_q    <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0000_0000;
      out_err_q   <= 1'b0;
      enc_q       <= 16'h0000;
      err_q       <= 16'h0000;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_rec_q    <= s1_rec_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      enc_q       <= enc_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = s1_ready_s;
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign enc_count = enc_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder: hand-computed encodings,
// range errors, backpressure, throughput, reset flush and counter corner cases.
module tb_inst_encoder;
  import rv32_enc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic        cnt_clr;
  logic [15:0] enc_count, err_count;

  int          n_chk = 0;
  int          n_err = 0;
  logic [32:0] exp_q[$];
  logic [32:0] held;
  logic        held_v = 1'b0;
  logic        rnd_rdy = 1'b0;
  int          tries;

  inst_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
    .cnt_clr(cnt_clr), .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: order/value scoreboard on hand-off, and stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) chk("stable", {31'd0, out_err, out_inst}, {31'd0, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 64'd1, 64'd0);
        else chk("word", {31'd0, out_err, out_inst}, {31'd0, exp_q.pop_front()});
      end
      held_v = out_valid && !out_ready;
      held   = {out_err, out_inst};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] e_inst, input logic e_err, output int n);
    logic acc;
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = in_ready;
      n++;
      tick();
    end
    in_valid = 1'b0;
    if (acc) exp_q.push_back({e_err, e_inst});
    else chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
    tick(); tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    chk("rst_enc", {48'd0, enc_count}, 64'd0);
    chk("rst_err", {48'd0, err_count}, 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Basic encodes; first one also checks two-cycle latency.
    send(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, tries);
    chk("lat_n1", {63'd0, out_valid}, 64'd0);
    tick();
    chk("lat_n2", {63'd0, out_valid}, 64'd1);
    send(3'd2, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0, tries);
    send(3'd3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, tries);
    send(3'd5, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 1'b0, tries);
    send(3'd4, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, tries);
    drain();
    chk("basic_enc", {48'd0, enc_count}, 64'd5);
    chk("basic_err", {48'd0, err_count}, 64'd0);

    // Range errors.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    send(3'd1, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0013, 1'b1, tries);
    send(3'd3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, 1'b1, tries);
    send(3'd4, OP_LUI, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_5037, 1'b1, tries);
    send(3'd7, OP_REG, 5'd3, 5'd4, 5'd5, 3'd1, 7'd1, 32'd0, 32'h0000_0013, 1'b1, tries);
    drain();
    chk("err_cnt4", {48'd0, err_count}, 64'd4);

    // Backpressure with random out_ready.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    rnd_rdy = 1'b1;
    for (int i = 1; i <= 10; i++)
      send(3'd0, OP_REG, 5'(i), 5'(i), 5'(i), 3'd0, 7'd0, 32'd0,
           (32'(i) << 20) | (32'(i) << 15) | (32'(i) << 7) | 32'h33, 1'b0, tries);
    rnd_rdy = 1'b0;
    drain();
    chk("bp_enc", {48'd0, enc_count}, 64'd10);

    // Full throughput: every record accepted on its first try.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    for (int i = 0; i < 100; i++) begin
      send(3'd1, OP_IMM, 5'(i % 32), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i),
           (32'(i) << 20) | (32'(i % 32) << 7) | 32'h13, 1'b0, tries);
      if (i % 10 == 0) chk("tput_tries", 64'(tries), 64'd1);
    end
    chk("tput_valid", {63'd0, out_valid}, 64'd1);
    drain();
    chk("tput_enc", {48'd0, enc_count}, 64'd100);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(3'd0, OP_REG, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 32'h0031_00B3, 1'b0, tries);
    send(3'd0, OP_REG, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0, 32'h0062_8233, 1'b0, tries);
    #1;
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    exp_q.delete();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rr_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rr_enc", {48'd0, enc_count}, 64'd0);
    chk("rr_err", {48'd0, err_count}, 64'd0);
    out_ready = 1'b1;
    tick();
    tick();
    chk("rr_empty", {63'd0, out_valid}, 64'd0);
    send(3'd2, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0, tries);
    chk("rr_lat1", {63'd0, out_valid}, 64'd0);
    tick();
    chk("rr_lat2", {63'd0, out_valid}, 64'd1);
    drain();
    chk("rr_enc1", {48'd0, enc_count}, 64'd1);

    // Clear on the same cycle as a hand-off.
    out_ready = 1'b0;
    send(3'd1, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0013, 1'b1, tries);
    tick();
    chk("clr_pre_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_enc", {48'd0, enc_count}, 64'd0);
    chk("clr_err", {48'd0, err_count}, 64'd0);

    // Wrap and saturation with a long run of error words.
    for (int i = 0; i < 65536; i++)
      send(3'd1, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0013, 1'b1, tries);
    drain();
    chk("wrap_enc", {48'd0, enc_count}, 64'd0);
    chk("sat_err_a", {48'd0, err_count}, 64'hFFFF);
    for (int i = 0; i < 4; i++)
      send(3'd1, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0013, 1'b1, tries);
    drain();
    chk("wrap_enc4", {48'd0, enc_count}, 64'd4);
    chk("sat_err_b", {48'd0, err_count}, 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
